// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Contents: FSM state encoding, default geometry and hold-timer width.
package loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam int unsigned ADDR_WIDTH_DEFAULT  = 12;
    localparam int unsigned DATA_WIDTH_DEFAULT  = 32;
    localparam int unsigned HOLD_CYCLES_DEFAULT = 4;
    localparam int unsigned HOLD_TIMER_WIDTH    = 4;

endpackage

// File: rtl/loader_hold_timer.sv
// Down counter that times the post-load hold phase.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   load          - load load_value into the counter
//   load_value    - cycles-minus-one to count
//   enable        - decrement while nonzero
//   expired_c     - counter is at zero (combinational)
module loader_hold_timer
    import loader_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        load,
    input  logic [HOLD_TIMER_WIDTH-1:0] load_value,
    input  logic                        enable,
    output logic                        expired_c
);

    logic [HOLD_TIMER_WIDTH-1:0] count;

    // Load wins over decrement; the counter parks at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - HOLD_TIMER_WIDTH'(1);
        end
    end

    assign expired_c = (count == '0);

endmodule

// File: rtl/imem_program_loader.sv
// Streams a program into instruction memory over a valid/ready word interface,
// holding the processor in reset while loading and for a short hold afterwards.
// Ports:
//   clock, reset           - system clock, synchronous active-high reset
//   start, word_count      - begin a load of word_count words (clamped to the depth)
//   in_valid, in_data      - incoming instruction words in address order
//   in_ready               - a word is accepted when in_valid & in_ready
//   imem_wren/address/data - registered imem write port
//   proc_reset             - processor reset request (low only while running)
//   busy                   - loading or holding
//   done                   - one-cycle pulse when the processor is released
module imem_program_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  imem_wren,
    output logic [ADDR_WIDTH-1:0] imem_address,
    output logic [DATA_WIDTH-1:0] imem_data,
    output logic                  proc_reset,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  word_total;
    logic [CNT_WIDTH-1:0]  word_total_next;
    logic [CNT_WIDTH-1:0]  word_index;
    logic [CNT_WIDTH-1:0]  word_index_next;
    logic [CNT_WIDTH-1:0]  clamped_count_c;
    logic                  accept_c;
    logic                  hold_load_c;
    logic                  hold_expired_c;
    logic                  wren_next;
    logic [ADDR_WIDTH-1:0] address_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic                  in_ready_next;
    logic                  proc_reset_next;
    logic                  busy_next;
    logic                  done_next;

    loader_hold_timer u_hold_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (hold_load_c),
        .load_value (HOLD_TIMER_WIDTH'(HOLD_CYCLES - 1)),
        .enable     (state == ST_HOLD),
        .expired_c  (hold_expired_c)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, counters and next values of the registered outputs.
    always_comb begin
        state_next      = state;
        word_total_next = word_total;
        word_index_next = word_index;
        wren_next       = 1'b0;
        address_next    = imem_address;
        data_next       = imem_data;
        hold_load_c     = 1'b0;
        accept_c        = in_valid & in_ready;
        // Counts above the depth (only the MSB set pattern and beyond) clamp to a full fill.
        clamped_count_c = word_count[ADDR_WIDTH] ? DEPTH : word_count;

        case (state)
            ST_IDLE, ST_RUN: begin
                if (start) begin
                    word_total_next = clamped_count_c;
                    word_index_next = '0;
                    if (clamped_count_c != '0) begin
                        state_next = ST_LOAD;
                    end else begin
                        state_next  = ST_HOLD;
                        hold_load_c = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (accept_c) begin
                    wren_next       = 1'b1;
                    address_next    = word_index[ADDR_WIDTH-1:0];
                    data_next       = in_data;
                    word_index_next = word_index + CNT_WIDTH'(1);
                    // Last word: ready drops next cycle so nothing extra is taken.
                    if (word_index_next == word_total) begin
                        state_next  = ST_HOLD;
                        hold_load_c = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_expired_c) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        in_ready_next   = (state_next == ST_LOAD);
        busy_next       = (state_next == ST_LOAD) || (state_next == ST_HOLD);
        proc_reset_next = (state_next != ST_RUN);
        done_next       = (state == ST_HOLD) && (state_next == ST_RUN);
    end

    // Counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            word_total   <= '0;
            word_index   <= '0;
            in_ready     <= 1'b0;
            imem_wren    <= 1'b0;
            imem_address <= '0;
            imem_data    <= '0;
            proc_reset   <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            word_total   <= word_total_next;
            word_index   <= word_index_next;
            in_ready     <= in_ready_next;
            imem_wren    <= wren_next;
            imem_address <= address_next;
            imem_data    <= data_next;
            proc_reset   <= proc_reset_next;
            busy         <= busy_next;
            done         <= done_next;
        end
    end

endmodule
